// File: rtl/bu2020_pkg.sv
// Shared widths, reset vector and queue entry layout for the BU2020 fetch path.
package bu2020_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/bu2020_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with async reset, synchronous clear and head read.
module bu2020_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_pop;
    logic             w_nonempty;

    assign w_nonempty = (r_count != '0);
    assign w_pop      = i_pop && w_nonempty;
    // When empty, keep presenting the most recently retired head.
    assign o_head     = w_nonempty ? r_mem[r_rd_ptr] : r_last;
    assign o_level    = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else if (i_clear) begin
            if (w_nonempty) r_last <= r_mem[r_rd_ptr];
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !i_clear && !w_pop && r_count == LW'(DEPTH)));

endmodule

// File: rtl/bu2020_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, captures 1-cycle-latency words, buffers them.
module bu2020_fetch_queue
    import bu2020_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_data,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_addr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [DATA_W-1:0]          instr_data,
    output logic [ADDR_W-1:0]          instr_addr,
    output logic [$clog2(DEPTH):0]     level
);

    logic [ADDR_W-1:0]     r_fetch_pc;
    logic                  r_resp_v;
    logic [ADDR_W-1:0]     r_resp_addr;
    logic [$clog2(DEPTH):0] w_level;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;

    // Credit: a word already in flight still needs a free slot when it lands.
    assign w_issue      = !flush && ((32'(w_level) + 32'(r_resp_v)) < DEPTH);
    assign w_push       = r_resp_v && !flush;
    assign w_pop        = instr_valid && instr_ready;
    assign w_push_entry = '{data: imem_data, addr: r_resp_addr};

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (w_level != '0);
    assign instr_data  = w_head.data;
    assign instr_addr  = w_head.addr;
    assign level       = w_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_resp_v    <= 1'b0;
            r_resp_addr <= '0;
        end else if (flush) begin
            r_fetch_pc <= flush_addr;
            r_resp_v   <= 1'b0;
        end else if (w_issue) begin
            r_resp_v    <= 1'b1;
            r_resp_addr <= r_fetch_pc;
            r_fetch_pc  <= r_fetch_pc + ADDR_W'(1);
        end else begin
            r_resp_v <= 1'b0;
        end
    end

    bu2020_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (flush),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (w_level)
    );

endmodule

// File: tb/tb_bu2020_fetch_queue.sv
// Self-checking bench for bu2020_fetch_queue: vector table, directed corner sequences, random stream.
module tb_bu2020_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] imem_addr;
    logic [15:0] imem_data = '0;
    logic        flush;
    logic [11:0] flush_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [11:0] instr_addr;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] m_q[$];
    bit          m_inf;
    logic [11:0] m_inf_addr;
    logic [11:0] m_pc;
    logic [11:0] dut_seen[$];

    typedef struct {
        bit          f;
        logic [11:0] fa;
        bit          rdy;
        bit          ev;
        logic [11:0] ea;
        logic [2:0]  el;
        logic [11:0] ei;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    bu2020_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .level       (level)
    );

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        return {4'h0, a} ^ 16'hA5A5;
    endfunction

    // Memory with a fixed one-cycle read latency.
    always @(posedge clk) imem_data <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inf = 1'b0;
        m_pc  = 12'h000;
    endtask

    // Queue-level model of one clock edge.
    task automatic model_edge(input bit f, input logic [11:0] fa, input bit rdy);
        int lvl;
        bit iss;
        lvl = m_q.size();
        if (f) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = fa;
        end else begin
            iss = (lvl + int'(m_inf)) < DEPTH;
            if (lvl != 0 && rdy) void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_inf_addr);
            m_inf = iss;
            if (iss) begin
                m_inf_addr = m_pc;
                m_pc       = m_pc + 12'd1;
            end
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(instr_valid), 32'(m_q.size() != 0));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        if (m_q.size() != 0) begin
            chk("head_addr", 32'(instr_addr), 32'(m_q[0]));
            chk("head_data", 32'(instr_data), 32'(mem_word(m_q[0])));
        end
    endtask

    task automatic cycle(input bit f, input logic [11:0] fa, input bit rdy);
        flush       = f;
        flush_addr  = fa;
        instr_ready = rdy;
        if (instr_valid && rdy) dut_seen.push_back(instr_addr);
        @(posedge clk);
        model_edge(f, fa, rdy);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_data"}, 32'(instr_data), 32'd0);
        chk({tag, "_addr"}, 32'(instr_addr), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_imem"}, 32'(imem_addr), 32'd0);
    endtask

    task automatic do_reset(input bit rdy);
        rst         = 1'b1;
        flush       = 1'b0;
        flush_addr  = '0;
        instr_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        model_reset();
        dut_seen.delete();
    endtask

    initial begin
        int n0;
        // Expected values from reset with ready high and mem[i] = i ^ A5A5.
        tbl[0] = '{f: 0, fa: 12'h0, rdy: 1, ev: 0, ea: 12'h000, el: 3'd0, ei: 12'h001};
        tbl[1] = '{f: 0, fa: 12'h0, rdy: 1, ev: 1, ea: 12'h000, el: 3'd1, ei: 12'h002};
        tbl[2] = '{f: 0, fa: 12'h0, rdy: 1, ev: 1, ea: 12'h001, el: 3'd1, ei: 12'h003};
        tbl[3] = '{f: 0, fa: 12'h0, rdy: 1, ev: 1, ea: 12'h002, el: 3'd1, ei: 12'h004};
        tbl[4] = '{f: 0, fa: 12'h0, rdy: 1, ev: 1, ea: 12'h003, el: 3'd1, ei: 12'h005};

        // 1: startup latency and sustained throughput
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].f, tbl[i].fa, tbl[i].rdy);
            chk("t1_valid", 32'(instr_valid), 32'(tbl[i].ev));
            chk("t1_level", 32'(level), 32'(tbl[i].el));
            chk("t1_imem", 32'(imem_addr), 32'(tbl[i].ei));
            if (tbl[i].ev) begin
                chk("t1_addr", 32'(instr_addr), 32'(tbl[i].ea));
                chk("t1_data", 32'(instr_data), 32'({4'h0, tbl[i].ea} ^ 16'hA5A5));
            end
        end

        // 2: backpressure saturates at DEPTH, then drains in order
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 12'h0, 1'b0);
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_imem_stop", 32'(imem_addr), 32'h004);
        for (int i = 0; i < 4; i++) cycle(1'b0, 12'h0, 1'b1);
        chk("t2_drain_cnt", 32'(dut_seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < dut_seen.size(); i++)
            chk("t2_drain_addr", 32'(dut_seen[i]), 32'(i));

        // 3: flush with a full credit window (3 queued + 1 in flight)
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 12'h0, 1'b0);
        chk("t3_pre_level", 32'(level), 32'd3);
        cycle(1'b1, 12'h123, 1'b0);
        chk("t3_flush_level", 32'(level), 32'd0);
        chk("t3_flush_valid", 32'(instr_valid), 32'd0);
        cycle(1'b0, 12'h0, 1'b0);
        chk("t3_e1_valid", 32'(instr_valid), 32'd0);
        cycle(1'b0, 12'h0, 1'b0);
        chk("t3_e2_valid", 32'(instr_valid), 32'd1);
        chk("t3_e2_addr", 32'(instr_addr), 32'h123);
        dut_seen.delete();
        for (int i = 0; i < 4; i++) cycle(1'b0, 12'h0, 1'b1);
        for (int i = 0; i < dut_seen.size(); i++)
            chk("t3_no_stale", 32'(dut_seen[i]), 32'(12'h123 + 12'(i)));

        // 4: address wrap-around
        cycle(1'b1, 12'hFFE, 1'b1);
        dut_seen.delete();
        for (int i = 0; i < 6; i++) cycle(1'b0, 12'h0, 1'b1);
        chk("t4_cnt", 32'(dut_seen.size()), 32'd4);
        if (dut_seen.size() >= 4) begin
            chk("t4_a0", 32'(dut_seen[0]), 32'hFFE);
            chk("t4_a1", 32'(dut_seen[1]), 32'hFFF);
            chk("t4_a2", 32'(dut_seen[2]), 32'h000);
            chk("t4_a3", 32'(dut_seen[3]), 32'h001);
        end

        // 5: flush coincident with a handshake
        chk("t5_pre_valid", 32'(instr_valid), 32'd1);
        n0 = dut_seen.size();
        cycle(1'b1, 12'h456, 1'b1);
        chk("t5_level", 32'(level), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 1'b1);
        chk("t5_cnt", 32'(dut_seen.size()), 32'(n0 + 2));
        if (dut_seen.size() >= n0 + 2) chk("t5_next", 32'(dut_seen[n0 + 1]), 32'h456);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("t6_async");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 1'b1);
        chk("t6_restart_addr", 32'(instr_addr), 32'h001);

        // Random stream against the queue model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(15) == 0), 12'($urandom), ($urandom_range(9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
